// File: rtl/multiplier_32b_reg_pp.sv
// multiplier_32b_reg_pp
//   Unsigned 32x32 -> 64-bit multiplier with a single output register
//   (one clock of latency, one product per cycle).
//   The 32 partial products are reduced by a balanced binary adder tree
//   in one cycle and captured into the output register.
//
// Ports:
//   iClk    clock, rising edge
//   iRstN   synchronous active-low reset (clears oData)
//   iEn     1 = capture new product, 0 = hold
//   iClr    synchronous clear of oData (wins over iEn)
//   iData0  operand A, unsigned 32-bit
//   iData1  operand B, unsigned 32-bit
//   oData   registered product A*B, unsigned 64-bit
module multiplier_32b_reg_pp (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iEn,
  input  logic                 iClr,
  input  logic [32-1:0]        iData0,
  input  logic [32-1:0]        iData1,
  output logic [64-1:0]        oData
);

  localparam int unsigned OpW    = 32;
  localparam int unsigned ProdW  = 2 * OpW;
  // Heap-ordered tree: leaves at [OpW-1 .. 2*OpW-2], root at [0].
  localparam int unsigned NumNodes = 2 * OpW - 1;
  localparam int unsigned FirstLeaf = OpW - 1;

  logic [ProdW-1:0] treeNode [NumNodes];
  logic [ProdW-1:0] productC;

  // Partial-product generation followed by pairwise reduction to the root.
  always_comb begin
    for (int i = 0; i < int'(NumNodes); i++) begin
      treeNode[i] = '0;
    end
    for (int k = 0; k < int'(OpW); k++) begin
      treeNode[int'(FirstLeaf) + k] = iData1[k] ? (ProdW'(iData0) << k) : '0;
    end
    for (int n = int'(FirstLeaf) - 1; n >= 0; n--) begin
      treeNode[n] = treeNode[2 * n + 1] + treeNode[2 * n + 2];
    end
    productC = treeNode[0];
  end

  // Output register: reset, then clear, then enable, else hold.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      oData <= '0;
    end else if (iClr) begin
      oData <= '0;
    end else if (iEn) begin
      oData <= productC;
    end
  end

endmodule

// File: tb/tb_multiplier_32b_reg_pp.sv
// Self-checking bench for multiplier_32b_reg_pp.
// Inputs are driven and oData is sampled on the falling edge of iClk.
module tb_multiplier_32b_reg_pp;

  logic        iClk;
  logic        iRstN;
  logic        iEn;
  logic        iClr;
  logic [31:0] iData0;
  logic [31:0] iData1;
  logic [63:0] oData;

  int numCompared;
  int numMismatched;

  multiplier_32b_reg_pp dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iEn    (iEn),
    .iClr   (iClr),
    .iData0 (iData0),
    .iData1 (iData1),
    .oData  (oData)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Safety bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rstN, input logic en, input logic clr,
                       input logic [31:0] a, input logic [31:0] b);
    iRstN  = rstN;
    iEn    = en;
    iClr   = clr;
    iData0 = a;
    iData1 = b;
  endtask

  logic [31:0] dirA   [5];
  logic [31:0] dirB   [5];
  logic [63:0] dirExp [5];

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    numCompared   = 0;
    numMismatched = 0;

    dirA[0] = 32'h0000_0000; dirB[0] = 32'h1234_5678; dirExp[0] = 64'h0;
    dirA[1] = 32'h0000_0001; dirB[1] = 32'hDEAD_BEEF; dirExp[1] = 64'h0000_0000_DEAD_BEEF;
    dirA[2] = 32'h8000_0000; dirB[2] = 32'h0000_0002; dirExp[2] = 64'h0000_0001_0000_0000;
    dirA[3] = 32'h0000_FFFF; dirB[3] = 32'h0000_FFFF; dirExp[3] = 64'h0000_0000_FFFE_0001;
    dirA[4] = 32'h1234_5678; dirB[4] = 32'h9ABC_DEF0; dirExp[4] = 64'h0B00_EA4E_242D_2080;

    // Reset held for two edges with max operands.
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge iClk);
    checkVal("reset_edge1", oData, 64'h0);
    @(negedge iClk);
    checkVal("reset_edge2", oData, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge iClk);
    checkVal("max_squared", oData, 64'hFFFF_FFFE_0000_0001);

    // Directed vectors, one per cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, dirA[i], dirB[i]);
      @(negedge iClk);
      checkVal($sformatf("directed%0d", i), oData, dirExp[i]);
    end

    // Random streaming with a one-edge reset pulse in the middle.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i == 50) begin
        drive(1'b0, 1'b1, 1'b0, ra, rb);
        @(negedge iClk);
        checkVal("midstream_reset", oData, 64'h0);
      end else begin
        drive(1'b1, 1'b1, 1'b0, ra, rb);
        @(negedge iClk);
        checkVal($sformatf("stream%0d", i), oData, 64'(ra) * 64'(rb));
      end
    end

    // Hold: capture 15, then change operands with iEn low.
    drive(1'b1, 1'b1, 1'b0, 32'd3, 32'd5);
    @(negedge iClk);
    checkVal("hold_capture", oData, 64'd15);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd7, 32'd9);
      @(negedge iClk);
      checkVal($sformatf("hold%0d", i), oData, 64'd15);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd7, 32'd9);
    @(negedge iClk);
    checkVal("hold_release", oData, 64'd63);

    // Clear wins over enable and holds while asserted.
    drive(1'b1, 1'b1, 1'b0, 32'd3, 32'd5);
    @(negedge iClk);
    checkVal("clr_setup", oData, 64'd15);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'd7, 32'd9);
      @(negedge iClk);
      checkVal($sformatf("clr%0d", i), oData, 64'd0);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd7, 32'd9);
    @(negedge iClk);
    checkVal("clr_release", oData, 64'd63);

    // Clear with iEn low still clears.
    drive(1'b1, 1'b0, 1'b1, 32'd7, 32'd9);
    @(negedge iClk);
    checkVal("clr_no_en", oData, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
